ft245_adc_streamer: RTL and testbench
=====================================

Name: ft245_adc_streamer

Overview:
Parametrised successor to the single-rate ADC-to-FT245 path. It generates the ADC sample clock from the system clock by a programmable divider and captures ADC_WIDTH-bit samples plus OTR. Samples are buffered in a word FIFO and streamed to the FT245 as two bytes per sample, high byte first. It adds an enable, overflow detection, and a byte counter that the single-rate path lacks. It sits between the PLL-derived system clock domain and the top-level pads; the top level owns the DATA_IO tristate.

Parameters:
ADC_WIDTH, 12, ADC data bits; legal range 8..15.
CLK_DIV, 10, system clocks per ADC_CLK period; even, at least 4.
FIFO_DEPTH, 16, sample-word FIFO depth; power of 2, at least 4.
WR_PULSE, 3, system clocks WR is held high.
WR_RECOV, 4, system clocks after WR falls before TXE is re-examined.

Ports:
CLK  in  1  system clock (100 MHz PLL output)
RST  in  1  synchronous reset, active-high
EN  in  1  capture enable
ADC_BIT  in  ADC_WIDTH  ADC data
ADC_OTR  in  1  ADC out-of-range
ADC_CLK  out  1  ADC sample clock
ADC_OE  out  1  ADC output enable, active-low
TXE  in  1  FT245 TXE#, asynchronous, active-low
RXF  in  1  FT245 RXF#; ignored
WR  out  1  FT245 write strobe; data latched on the falling edge
RD  out  1  FT245 RD#; held at 1
DATA_OUT  out  8  byte to the pads
DATA_OE  out  1  1 = the top level drives DATA_IO from DATA_OUT
OVF  out  1  sticky FIFO-overflow flag
BYTE_CNT  out  32  bytes written since reset; wraps

Behaviour:
Reset values (on RST=1 at a clock edge):
- ADC_CLK=0, ADC_OE=1, WR=0, RD=1, DATA_OUT=0, DATA_OE=0, OVF=0, BYTE_CNT=0.
- Divider=0, FIFO empty, FSM=IDLE, TXE synchroniser=11.
- Reset mid-write drops WR on that edge; any partially sent word is discarded.

Divider and ADC control:
- div counts 0..CLK_DIV-1 and only while EN=1. When EN=0, div is held at 0.
- ADC_CLK=1 when div < CLK_DIV/2, registered.
- ADC_OE = !EN, registered.

Capture:
- When EN=1 and div==CLK_DIV-1, register word = {ADC_OTR, (15-ADC_WIDTH) zeros, ADC_BIT} and push it the next cycle.
- Push into a full FIFO: drop the word and set OVF=1.
- OVF clears only on RST or on an EN 0->1 transition.
- Push and pop in the same cycle are both legal, including when the FIFO is full: count is unchanged and no overflow occurs.

TXE synchroniser:
- 2-flop synchroniser; txe_ok = !txe_s2.

Write FSM (byte_sel: 0 = high byte, 1 = low byte):
- IDLE: if FIFO not empty and txe_ok, pop the word into hold, byte_sel=0, go to SETUP.
- SETUP (1 cycle): DATA_OE=1; DATA_OUT = hold[15:8] if byte_sel=0, else hold[7:0]. Go to STROBE.
- STROBE (WR_PULSE cycles): WR=1, data held stable. On exit WR=0 and BYTE_CNT increments.
- RECOV (WR_RECOV cycles): DATA_OE stays 1 for the first cycle and is 0 afterwards.
  - On exit with byte_sel=0: byte_sel=1, go to WAIT_LO.
  - On exit with byte_sel=1: go to IDLE.
- WAIT_LO: if txe_ok, go to SETUP; otherwise stay, with no timeout.
- Minimum per byte: 1+WR_PULSE+WR_RECOV cycles = 8 at defaults.
- EN=0 does not abort a word in flight; remaining FIFO contents still drain.
- BYTE_CNT wraps from 0xFFFFFFFF to 0.

Decomposition:
- Package ft245_adc_pkg: FSM state enum (IDLE, SETUP, STROBE, RECOV, WAIT_LO), WORD_W=16, byte-order constant HI_FIRST=1.
- Sub-module sync_fifo (WIDTH, DEPTH): single clock, synchronous active-high reset, push/pop/full/empty/count, read data registered on pop.

Test Plan:
- Reset, EN=1, ADC_BIT=0xABC, OTR=0, TXE=0 -> ADC_CLK period 10 cycles, high for 5; bytes 0x0A then 0xBC; WR high 3 cycles each; BYTE_CNT=2 after the first word.
- OTR=1 with ADC_BIT=0x001 -> bytes 0x80, 0x01.
- TXE held at 1 for 20 samples -> FIFO fills at 16, OVF=1, no WR. After TXE=0 -> exactly 32 bytes, matching the first 16 samples in order.
- TXE raised between the high and low byte of a word -> FSM waits in WAIT_LO; the low byte goes out 3 to 4 cycles after TXE returns to 0, with no duplicated byte.
- RST=1 during STROBE -> next edge WR=0, DATA_OE=0, BYTE_CNT=0, FIFO empty.
- EN 1->0->1 after overflow -> ADC_OE follows !EN one cycle later, OVF clears on re-enable, div restarts at 0.

Source files
------------

// File: rtl/ft245_adc_pkg.sv
// Shared types and constants for the ADC-to-FT245 streaming path.
package ft245_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOV,
    WAIT_LO
  } wr_state_t;

  localparam int WORD_W   = 16;
  localparam bit HI_FIRST = 1'b1;

endpackage

// File: rtl/ft245_adc_streamer_fifo.sv
// Single-clock word FIFO; read data is registered on pop and holds until the next pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so push into a full FIFO is accepted then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/ft245_adc_streamer.sv
// ADC sample-clock divider and capture, word FIFO, and FT245 byte-write engine
// sending each 16-bit sample high byte first.
module ft245_adc_streamer
  import ft245_adc_pkg::*;
#(
  parameter int ADC_WIDTH  = 12,
  parameter int CLK_DIV    = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_PULSE   = 3,
  parameter int WR_RECOV   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [ADC_WIDTH-1:0] ADC_BIT,
  input  logic                 ADC_OTR,
  output logic                 ADC_CLK,
  output logic                 ADC_OE,
  input  logic                 TXE,
  input  logic                 RXF,
  output logic                 WR,
  output logic                 RD,
  output logic [7:0]           DATA_OUT,
  output logic                 DATA_OE,
  output logic                 OVF,
  output logic [31:0]          BYTE_CNT
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMR_W = $clog2(((WR_PULSE > WR_RECOV) ? WR_PULSE : WR_RECOV) + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [WORD_W-1:0] pack_sample(input logic otr,
                                                    input logic [ADC_WIDTH-1:0] bits);
    logic [WORD_W-1:0] w;
    w                 = '0;
    w[ADC_WIDTH-1:0]  = bits;
    w[WORD_W-1]       = otr;
    return w;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w, input logic sel);
    if (sel == !HI_FIRST) return w[WORD_W-1 -: 8];
    else                  return w[7:0];
  endfunction

  logic [DIV_W-1:0]  div;
  logic              en_q;
  logic              last_phase;
  logic              vld_p1;
  logic [WORD_W-1:0] cap_word_p1;

  logic              txe_s1;
  logic              txe_s2;
  logic              txe_ok;

  logic              fifo_pop;
  logic [WORD_W-1:0] hold;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  wr_state_t         state;
  wr_state_t         state_n;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_n;
  logic              byte_sel;
  logic              byte_sel_n;
  logic              cnt_inc;
  logic              wr_n;
  logic              oe_n;
  logic              unused_ok;

  assign last_phase = (div == DIV_W'(CLK_DIV - 1));
  assign txe_ok     = !txe_s2;
  assign RD         = 1'b1;
  assign unused_ok  = ^{RXF, fifo_count};

  // Stage p0 -> p1: sample-clock generation and ADC word capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      div     <= '0;
      ADC_CLK <= 1'b0;
      ADC_OE  <= 1'b1;
      en_q    <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      en_q    <= EN;
      ADC_OE  <= !EN;
      ADC_CLK <= (div < DIV_W'(CLK_DIV / 2));
      vld_p1  <= EN && last_phase;
      if (!EN || last_phase) div <= '0;
      else                   div <= div + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (EN && last_phase) cap_word_p1 <= pack_sample(ADC_OTR, ADC_BIT);
  end

  // Stage p1 -> FIFO: the captured word is pushed one cycle after capture
  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (vld_p1),
    .push_data (cap_word_p1),
    .pop       (fifo_pop),
    .rd_data   (hold),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_n    = state;
    tmr_n      = tmr;
    byte_sel_n = byte_sel;
    fifo_pop   = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && txe_ok) begin
          fifo_pop   = 1'b1;
          byte_sel_n = 1'b0;
          state_n    = SETUP;
        end
      end
      SETUP: begin
        tmr_n   = '0;
        state_n = STROBE;
      end
      STROBE: begin
        if (tmr == TMR_W'(WR_PULSE - 1)) begin
          tmr_n   = '0;
          cnt_inc = 1'b1;
          state_n = RECOV;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      RECOV: begin
        if (tmr == TMR_W'(WR_RECOV - 1)) begin
          tmr_n = '0;
          if (!byte_sel) begin
            byte_sel_n = 1'b1;
            state_n    = WAIT_LO;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      WAIT_LO: begin
        if (txe_ok) state_n = SETUP;
      end
      default: state_n = IDLE;
    endcase
    // Pad controls are registered from the next state so they change with the state itself.
    wr_n = (state_n == STROBE);
    oe_n = (state_n == SETUP) || (state_n == STROBE) || ((state_n == RECOV) && (tmr_n == '0));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      tmr      <= '0;
      byte_sel <= 1'b0;
      WR       <= 1'b0;
      DATA_OE  <= 1'b0;
      BYTE_CNT <= '0;
      OVF      <= 1'b0;
      txe_s1   <= 1'b1;
      txe_s2   <= 1'b1;
    end else begin
      txe_s1   <= TXE;
      txe_s2   <= txe_s1;
      state    <= state_n;
      tmr      <= tmr_n;
      byte_sel <= byte_sel_n;
      WR       <= wr_n;
      DATA_OE  <= oe_n;
      if (cnt_inc) BYTE_CNT <= BYTE_CNT + 32'd1;
      if (EN && !en_q)                          OVF <= 1'b0;
      else if (vld_p1 && fifo_full && !fifo_pop) OVF <= 1'b1;
    end
  end

  // The popped word stays in the FIFO read register for both bytes of the word.
  assign DATA_OUT = DATA_OE ? pick_byte(hold, byte_sel) : 8'h00;

endmodule

// File: tb/tb_ft245_adc_streamer.sv
// Directed bench for ft245_adc_streamer: vector table plus multi-cycle corner sequences.
module tb_ft245_adc_streamer;

  typedef struct {
    logic [11:0] bits;
    logic        otr;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        adc_otr = 1'b0;
  logic        txe = 1'b1;
  logic        rxf = 1'b1;
  logic [11:0] vec_bit = 12'h000;
  logic [11:0] model_val = 12'h0A5;
  logic        model_on = 1'b0;
  logic [11:0] adc_bit;

  logic        adc_clk, adc_oe, wr, rd, data_oe, ovf;
  logic [7:0]  data_out;
  logic [31:0] byte_cnt;

  assign adc_bit = model_on ? model_val : vec_bit;

  ft245_adc_streamer dut (
    .CLK      (clk),
    .RST      (rst),
    .EN       (en),
    .ADC_BIT  (adc_bit),
    .ADC_OTR  (adc_otr),
    .ADC_CLK  (adc_clk),
    .ADC_OE   (adc_oe),
    .TXE      (txe),
    .RXF      (rxf),
    .WR       (wr),
    .RD       (rd),
    .DATA_OUT (data_out),
    .DATA_OE  (data_oe),
    .OVF      (ovf),
    .BYTE_CNT (byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FT245 side and ADC side models, sampled on the falling edge
  logic [7:0]  bytes[$];
  int          rise_cyc[$];
  logic [11:0] exp_q[$];
  int          falls = 0, adc_falls = 0, wr_len = 0;
  int          len_bad = 0, stable_bad = 0, oe_bad = 0;
  logic        wr_prev = 1'b0, adc_prev = 1'b0;
  logic [7:0]  cur_byte = 8'h00;

  initial forever begin
    @(negedge clk);
    if (model_on && adc_prev && !adc_clk) begin
      model_val = model_val + 12'h123;
      exp_q.push_back(model_val);
      adc_falls++;
    end
    adc_prev = adc_clk;
    if (wr && !wr_prev) begin
      bytes.push_back(data_out);
      rise_cyc.push_back(cyc);
      cur_byte = data_out;
      wr_len = 1;
    end else if (wr && wr_prev) begin
      wr_len++;
      if (data_out !== cur_byte) stable_bad++;
    end
    if (wr && !data_oe) oe_bad++;
    if (!wr && wr_prev) begin
      falls++;
      if (!rst && wr_len != 3) len_bad++;
    end
    wr_prev = wr;
  end

  int checks = 0, failures = 0;
  int b0 = 0, f0 = 0, e0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_base();
    b0 = bytes.size();
    f0 = falls;
    e0 = exp_q.size();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick(2);
    rst = 1'b0;
    set_base();
  endtask

  task automatic wait_bytes(input int n, input int budget, input string nm);
    int k = 0;
    while ((bytes.size() - b0) < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, ((bytes.size() - b0) >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  vec_t vecs[5];
  int   en_cyc, t0, mism, d, k;

  initial begin
    vecs[0] = '{bits: 12'hABC, otr: 1'b0, hi: 8'h0A, lo: 8'hBC};
    vecs[1] = '{bits: 12'h001, otr: 1'b1, hi: 8'h80, lo: 8'h01};
    vecs[2] = '{bits: 12'hFFF, otr: 1'b0, hi: 8'h0F, lo: 8'hFF};
    vecs[3] = '{bits: 12'h000, otr: 1'b1, hi: 8'h80, lo: 8'h00};
    vecs[4] = '{bits: 12'h5A5, otr: 1'b1, hi: 8'h85, lo: 8'hA5};

    // Reset values while RST is held
    txe = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("rst_adc_clk", adc_clk, 0);
    chk("rst_adc_oe", adc_oe, 1);
    chk("rst_wr", wr, 0);
    chk("rst_rd", rd, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_byte_cnt", byte_cnt, 0);

    // Table: one word per vector, high byte first
    for (int i = 0; i < 5; i++) begin
      vec_bit = vecs[i].bits;
      adc_otr = vecs[i].otr;
      do_reset();
      tick(3);
      en = 1'b1;
      en_cyc = cyc;
      wait_bytes(2, 200, $sformatf("vec%0d_timeout", i));
      k = 0;
      while ((falls - f0) < 2 && k < 30) begin
        tick(1);
        k++;
      end
      chk($sformatf("vec%0d_hi", i), bytes[b0], vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bytes[b0+1], vecs[i].lo);
      chk($sformatf("vec%0d_first_wr_latency", i), rise_cyc[b0] - en_cyc, 13);
      chk($sformatf("vec%0d_byte_cnt", i), byte_cnt, 2);
    end

    // TXE deasserted between the high and low byte
    vec_bit = 12'h123;
    adc_otr = 1'b0;
    do_reset();
    tick(3);
    en = 1'b1;
    wait_bytes(1, 100, "waitlo_first_timeout");
    txe = 1'b1;
    tick(30);
    chk("waitlo_no_byte", bytes.size() - b0, 1);
    chk("waitlo_data_oe", data_oe, 0);
    txe = 1'b0;
    t0 = cyc;
    wait_bytes(2, 20, "waitlo_resume_timeout");
    d = rise_cyc[b0+1] - t0;
    chk("waitlo_latency_3to4", (d >= 3 && d <= 4) ? 32'd1 : 32'd0, 1);
    chk("waitlo_lo_byte", bytes[b0+1], 8'h23);
    wait_bytes(3, 60, "waitlo_next_timeout");
    chk("waitlo_no_dup", bytes[b0+2], 8'h01);

    // Reset during STROBE
    vec_bit = 12'h3C5;
    do_reset();
    tick(3);
    en = 1'b1;
    wait_bytes(1, 100, "strobe_timeout");
    chk("strobe_wr_high", wr, 1);
    rst = 1'b1;
    tick(1);
    chk("strobe_rst_wr", wr, 0);
    chk("strobe_rst_data_oe", data_oe, 0);
    chk("strobe_rst_byte_cnt", byte_cnt, 0);
    chk("strobe_rst_ovf", ovf, 0);
    tick(1);
    rst = 1'b0;
    en  = 1'b0;
    set_base();
    tick(40);
    chk("strobe_rst_fifo_empty", bytes.size() - b0, 0);

    // Overflow with TXE held high, ADC clock shape, then drain
    txe = 1'b1;
    do_reset();
    tick(3);
    model_on = 1'b1;
    tick(1);
    set_base();
    en = 1'b1;
    mism = 0;
    for (int j = 1; j <= 40; j++) begin
      tick(1);
      if (adc_clk !== ((((j - 1) % 10) < 5) ? 1'b1 : 1'b0)) mism++;
    end
    chk("adc_clk_period10_high5", mism, 0);
    k = 0;
    while ((exp_q.size() - e0) < 20 && k < 300) begin
      tick(1);
      k++;
    end
    chk("ovf_samples_timeout", ((exp_q.size() - e0) >= 20) ? 32'd1 : 32'd0, 1);
    tick(8);
    chk("adc_oe_before_disable", adc_oe, 0);
    en = 1'b0;
    chk("ovf_set", ovf, 1);
    chk("ovf_no_wr", falls - f0, 0);
    tick(1);
    chk("adc_oe_after_disable", adc_oe, 1);
    model_on = 1'b0;
    txe = 1'b0;
    wait_bytes(32, 800, "drain_timeout");
    tick(60);
    chk("drain_count", bytes.size() - b0, 32);
    for (int w = 0; w < 16; w++) begin
      chk($sformatf("drain_word%0d", w), {bytes[b0+2*w], bytes[b0+2*w+1]},
          {4'h0, exp_q[e0+w]});
    end
    chk("drain_byte_cnt", byte_cnt, 32);
    chk("ovf_sticky_en_low", ovf, 1);

    // Re-enable clears OVF and restarts the divider
    en = 1'b1;
    mism = 0;
    for (int j = 1; j <= 10; j++) begin
      tick(1);
      if (j == 1) begin
        chk("reen_ovf_clear", ovf, 0);
        chk("reen_adc_oe", adc_oe, 0);
      end
      if (adc_clk !== ((((j - 1) % 10) < 5) ? 1'b1 : 1'b0)) mism++;
    end
    chk("reen_div_restart", mism, 0);

    chk("wr_pulse_len", len_bad, 0);
    chk("data_stable_during_wr", stable_bad, 0);
    chk("data_oe_during_wr", oe_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
